// File: rtl/regfile_scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard_pkg
// Shared constants for the register file with scoreboard:
//   - default data and address widths
//   - the index of the hardwired-zero register
// -----------------------------------------------------------------------------
package regfile_scoreboard_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  // Register index that reads as zero and never becomes pending when the
  // zero-register option is enabled.
  localparam int ZERO_IDX = 0;

endpackage : regfile_scoreboard_pkg

// File: rtl/regfile_scoreboard_sb.sv
// -----------------------------------------------------------------------------
// rf_scoreboard
// One pending bit per architectural register plus a registered population
// count. An issue reserves a destination, a writeback releases it; when both
// hit the same register in one cycle the reservation wins.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   iss_en, iss_addr    issue strobe and destination to reserve
//   wr_en, wr_addr      writeback strobe and destination to release
//   rd_addr1, rd_addr2  source addresses to test
//   busy1, busy2        source has an outstanding producer (writeback in the
//                       same cycle cancels it, matching the data bypass)
//   pend_cnt            number of pending registers, updated with the bits
// -----------------------------------------------------------------------------
module rf_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_addr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic              busy1,
  output logic              busy2,
  output logic [ADDR_W:0]   pend_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0] pend;
  logic [DEPTH-1:0] pend_nxt;
  logic [ADDR_W:0]  cnt_nxt;

  // Next pending vector: clear on writeback first, then set on issue so a
  // same-register collision leaves the bit set.
  always_comb begin
    // NOTE: every always_comb target gets a default first; a path that leaves
    // a signal unassigned would infer a latch.
    pend_nxt = pend;
    if (wr_en)  pend_nxt[wr_addr]  = 1'b0;
    if (iss_en) pend_nxt[iss_addr] = 1'b1;
    if (ZERO_REG != 0) pend_nxt[ZERO_IDX] = 1'b0;
  end

  // The count is taken from the next vector so it lands on the same edge as
  // the bits it describes; it cannot exceed DEPTH, so it never wraps.
  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt_nxt = cnt_nxt + {{ADDR_W{1'b0}}, pend_nxt[i]};
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      pend     <= '0;
      pend_cnt <= '0;
    end else begin
      pend     <= pend_nxt;
      pend_cnt <= cnt_nxt;
    end
  end

  assign busy1 = pend[rd_addr1] & ~(wr_en & (wr_addr == rd_addr1));
  assign busy2 = pend[rd_addr2] & ~(wr_en & (wr_addr == rd_addr2));

endmodule : rf_scoreboard

// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
// Two-read, one-write register file with write-first bypass and an attached
// pending-bit scoreboard for in-order issue hazard detection.
//
// Ports
//   clk, rst_n                    clock, synchronous active-low reset
//   rd_addr1/2, rd_data1/2        combinational read ports (bypassed)
//   wr_en, wr_addr, wr_data       writeback port; also releases the pending bit
//   iss_en, iss_addr              issue port; reserves the destination
//   busy1/2                       addressed source still awaits its producer
//   stall                         busy1 | busy2
//   pend_cnt                      registered count of pending registers
// -----------------------------------------------------------------------------
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_addr,
  output logic              busy1,
  output logic              busy2,
  output logic              stall,
  output logic [ADDR_W:0]   pend_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_IDX);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_ok;

  // Writes to the hardwired register are dropped so it never holds data.
  assign wr_ok = wr_en && !((ZERO_REG != 0) && (wr_addr == ZERO_ADDR));

  always_ff @(posedge clk) begin
    // NOTE: the storage array is reset because every register must read zero
    // after reset; this keeps it in flops rather than an inferred RAM.
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read path priority: hardwired zero, then same-cycle writeback, then array.
  always_comb begin
    rd_data1 = mem[rd_addr1];
    if (wr_en && (wr_addr == rd_addr1))                    rd_data1 = wr_data;
    if ((ZERO_REG != 0) && (rd_addr1 == ZERO_ADDR))        rd_data1 = '0;
  end

  always_comb begin
    rd_data2 = mem[rd_addr2];
    if (wr_en && (wr_addr == rd_addr2))                    rd_data2 = wr_data;
    if ((ZERO_REG != 0) && (rd_addr2 == ZERO_ADDR))        rd_data2 = '0;
  end

  rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .rd_addr1 (rd_addr1),
    .rd_addr2 (rd_addr2),
    .busy1    (busy1),
    .busy2    (busy2),
    .pend_cnt (pend_cnt)
  );

  assign stall = busy1 | busy2;

endmodule : regfile_scoreboard

// File: tb/tb_regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_regfile_scoreboard
// Directed scenarios followed by randomized traffic, all compared against an
// array-based reference model of the register file and reservation set.
// -----------------------------------------------------------------------------
module tb_regfile_scoreboard;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [ADDR_W-1:0] rd_addr1, rd_addr2;
  logic [DATA_W-1:0] rd_data1, rd_data2;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              iss_en;
  logic [ADDR_W-1:0] iss_addr;
  logic              busy1, busy2, stall;
  logic [ADDR_W:0]   pend_cnt;

  regfile_scoreboard #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_addr1 (rd_addr1),
    .rd_addr2 (rd_addr2),
    .rd_data1 (rd_data1),
    .rd_data2 (rd_data2),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .busy1    (busy1),
    .busy2    (busy2),
    .stall    (stall),
    .pend_cnt (pend_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: register contents and the set of reserved registers.
  logic [DATA_W-1:0] ref_mem  [DEPTH];
  bit                ref_pend [DEPTH];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] exp_rd(input int a);
    if (a == 0)                     return '0;
    if (wr_en && (int'(wr_addr) == a)) return wr_data;
    return ref_mem[a];
  endfunction

  function automatic bit exp_busy(input int a);
    return ref_pend[a] && !(wr_en && (int'(wr_addr) == a));
  endfunction

  function automatic int ref_count();
    int n = 0;
    foreach (ref_pend[i]) if (ref_pend[i]) n++;
    return n;
  endfunction

  // One clock: compare outputs mid-cycle, advance the model on the edge, then
  // return just after the edge so the caller can drive the next inputs.
  task automatic tick(input bit do_check, input string phase);
    bit b1, b2;
    @(negedge clk);
    if (do_check) begin
      check({phase, " pend_cnt"}, 64'(pend_cnt), 64'(ref_count()));
      if (rst_n) begin
        b1 = exp_busy(int'(rd_addr1));
        b2 = exp_busy(int'(rd_addr2));
        check({phase, " rd_data1"}, 64'(rd_data1), 64'(exp_rd(int'(rd_addr1))));
        check({phase, " rd_data2"}, 64'(rd_data2), 64'(exp_rd(int'(rd_addr2))));
        check({phase, " busy1"},    64'(busy1),    64'(b1));
        check({phase, " busy2"},    64'(busy2),    64'(b2));
        check({phase, " stall"},    64'(stall),    64'(b1 | b2));
      end
    end
    @(posedge clk);
    if (!rst_n) begin
      foreach (ref_mem[i])  ref_mem[i]  = '0;
      foreach (ref_pend[i]) ref_pend[i] = 1'b0;
    end else begin
      if (wr_en && wr_addr != 0)   ref_mem[wr_addr] = wr_data;
      if (wr_en)                   ref_pend[wr_addr] = 1'b0;
      if (iss_en && iss_addr != 0) ref_pend[iss_addr] = 1'b1;
    end
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; iss_en = 1'b0;
    wr_addr = '0; wr_data = '0; iss_addr = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    rd_addr1 = '0; rd_addr2 = '0;
    idle();
    tick(1'b0, "init");
    tick(1'b1, "reset");
    rst_n = 1'b1;

    // Every address reads zero and idle after reset.
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr1 = ADDR_W'(a);
      rd_addr2 = ADDR_W'(DEPTH - 1 - a);
      tick(1'b1, "post_reset");
    end

    // Bypass in the writeback cycle, then the stored value a cycle later.
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hDEADBEEF; rd_addr1 = 5'd7;
    #1 check("bypass same cycle", 64'(rd_data1), 64'hDEADBEEF);
    tick(1'b1, "bypass");
    idle();
    #1 check("bypass stored", 64'(rd_data1), 64'hDEADBEEF);
    tick(1'b1, "bypass_after");

    // Register zero ignores writes and reservations.
    wr_en = 1'b1; wr_addr = '0; wr_data = 32'h1234; iss_en = 1'b1; iss_addr = '0;
    rd_addr1 = '0; rd_addr2 = '0;
    tick(1'b1, "zero");
    idle();
    #1;
    check("zero rd_data1", 64'(rd_data1), 64'h0);
    check("zero busy1",    64'(busy1),    64'h0);
    check("zero pend_cnt", 64'(pend_cnt), 64'h0);
    tick(1'b1, "zero_after");

    // Reserve register 5, then release it.
    iss_en = 1'b1; iss_addr = 5'd5; rd_addr1 = 5'd5;
    tick(1'b1, "issue5");
    idle();
    #1;
    check("issue5 busy1",    64'(busy1),    64'h1);
    check("issue5 pend_cnt", 64'(pend_cnt), 64'h1);
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h55;
    #1 check("wb5 busy1 cancelled", 64'(busy1), 64'h0);
    tick(1'b1, "wb5");
    idle();
    #1 check("wb5 pend_cnt", 64'(pend_cnt), 64'h0);

    // Same-cycle issue and writeback: reservation holds, data lands.
    iss_en = 1'b1; iss_addr = 5'd9; wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hA5A5_0909;
    rd_addr1 = 5'd9;
    tick(1'b1, "collide");
    idle();
    #1;
    check("collide busy1",    64'(busy1),    64'h1);
    check("collide rd_data1", 64'(rd_data1), 64'hA5A5_0909);
    check("collide pend_cnt", 64'(pend_cnt), 64'h1);

    // Reserve everything but register zero, re-issue one, then reset.
    for (int a = 1; a < DEPTH; a++) begin
      iss_en = 1'b1; iss_addr = ADDR_W'(a);
      tick(1'b1, "fill");
    end
    check("fill pend_cnt", 64'(pend_cnt), 64'd31);
    iss_en = 1'b1; iss_addr = 5'd3;
    tick(1'b1, "reissue");
    idle();
    check("reissue pend_cnt", 64'(pend_cnt), 64'd31);
    rst_n = 1'b0; wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'hFFFF; iss_en = 1'b1; iss_addr = 5'd0;
    tick(1'b1, "mid_reset");
    rst_n = 1'b1; idle();
    rd_addr1 = 5'd9; rd_addr2 = 5'd4;
    #1;
    check("mid_reset pend_cnt", 64'(pend_cnt), 64'h0);
    check("mid_reset rd_data1", 64'(rd_data1), 64'h0);
    check("mid_reset rd_data2", 64'(rd_data2), 64'h0);
    check("mid_reset busy1",    64'(busy1),    64'h0);
    tick(1'b1, "post_mid_reset");

    // Randomized traffic with small address ranges to force hazards.
    for (int n = 0; n < 3000; n++) begin
      rst_n    = ($urandom_range(0, 199) != 0);
      wr_en    = ($urandom_range(0, 2) != 0);
      iss_en   = ($urandom_range(0, 2) != 0);
      wr_addr  = ADDR_W'($urandom_range(0, (n % 2) ? 31 : 7));
      iss_addr = ADDR_W'($urandom_range(0, (n % 2) ? 31 : 7));
      wr_data  = $urandom;
      rd_addr1 = ($urandom_range(0, 3) == 0) ? wr_addr : ADDR_W'($urandom_range(0, 31));
      rd_addr2 = ADDR_W'($urandom_range(0, (n % 2) ? 31 : 7));
      tick(1'b1, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_regfile_scoreboard
